// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: ID->EX stage buffer.
// A DEPTH-entry FIFO of decoded micro-ops with a valid/ready handshake on both sides.
// When empty, it presents a NOP bubble (all out_* zero, write-back disabled) toward EX.
// A synchronous flush discards every entry for branch and exception redirect.
// Optional: define ID_EX_PERF_EN to add the perf_bubble/perf_stall saturating counters.
// DEPTH must be a power of two and >= 2, so the pointers can wrap naturally.
module id_ex_stage_buf #(
  parameter int PAYLOAD_W = 72,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 2,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [ADDR_W-1:0]    in_wd,
  input  logic                 in_wreg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [ADDR_W-1:0]    out_wd,
  output logic                 out_wreg,
  output logic [CNT_W-1:0]     occupancy
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]          perf_bubble,
  output logic [31:0]          perf_stall
`endif
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_W-1:0]    wd;
    logic                 wreg;
  } uop_t;

  uop_t             mem [DEPTH];
  uop_t             in_uop;
  uop_t             head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             enq, deq;

  assign in_uop    = '{payload: in_payload, wd: in_wd, wreg: in_wreg};
  // in_ready is derived only from registered count.
  // This keeps any combinational path from out_ready out of it.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign occupancy = count;

  // Head entry, or an all-zero NOP bubble when the buffer is empty.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_payload = head.payload;
  assign out_wd      = head.wd;
  assign out_wreg    = head.wreg;

  // Storage is not reset. Entries are only observable while count covers them.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= in_uop;
  end

  // Pointers and count. Flush wins over the enq/deq of the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ID_EX_PERF_EN
  // Saturating event counters. Only rst clears them; flush leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bubble <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_ready && !out_valid && perf_bubble != '1) perf_bubble <= perf_bubble + 32'd1;
      if (in_valid && !in_ready && perf_stall != '1)    perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed and random checks of id_ex_stage_buf against a queue-based reference model.
module tb_id_ex_stage_buf;
  localparam int PW    = 72;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_payload = '0;
  logic [AW-1:0] in_wd = '0;
  logic          in_wreg = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_payload;
  logic [AW-1:0] out_wd;
  logic          out_wreg;
  logic [CW-1:0] occupancy;
`ifdef ID_EX_PERF_EN
  logic [31:0]   perf_bubble, perf_stall;
`endif

  id_ex_stage_buf #(.PAYLOAD_W(PW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_wd(in_wd), .in_wreg(in_wreg),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_wd(out_wd), .out_wreg(out_wreg), .occupancy(occupancy)
`ifdef ID_EX_PERF_EN
    , .perf_bubble(perf_bubble), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [AW-1:0] wd;
    logic          wreg;
  } ent_t;

  ent_t     q[$];
  longint   m_bubble = 0;
  longint   m_stall  = 0;
  int       n_cmp = 0;
  int       n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic check_all(input string ph);
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({ph, ".out_valid"},   128'(out_valid),   128'(q.size() != 0));
    chk({ph, ".in_ready"},    128'(in_ready),    128'(q.size() < DEPTH));
    chk({ph, ".occupancy"},   128'(occupancy),   128'(q.size()));
    chk({ph, ".out_payload"}, 128'(out_payload), 128'(h.p));
    chk({ph, ".out_wd"},      128'(out_wd),      128'(h.wd));
    chk({ph, ".out_wreg"},    128'(out_wreg),    128'(h.wreg));
`ifdef ID_EX_PERF_EN
    chk({ph, ".perf_bubble"}, 128'(perf_bubble), 128'(m_bubble));
    chk({ph, ".perf_stall"},  128'(perf_stall),  128'(m_stall));
`endif
  endtask

  // Advance one clock. The model decides enq/deq from its pre-edge occupancy.
  task automatic step(input string ph);
    bit e, d;
    @(posedge clk);
    e = in_valid && (q.size() < DEPTH);
    d = out_ready && (q.size() != 0);
    if (out_ready && q.size() == 0 && m_bubble < 64'hFFFF_FFFF) m_bubble++;
    if (in_valid && q.size() == DEPTH && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (flush) q.delete();
    else begin
      if (d) void'(q.pop_front());
      if (e) q.push_back('{p: in_payload, wd: in_wd, wreg: in_wreg});
    end
    #1;
    check_all(ph);
  endtask

  task automatic drive(input bit v, input logic [PW-1:0] p, input logic [AW-1:0] wd,
                       input bit wr, input bit ordy, input bit fl);
    in_valid = v; in_payload = p; in_wd = wd; in_wreg = wr; out_ready = ordy; flush = fl;
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    return PW'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    logic [PW-1:0] A, B, C, prev;

    // 1 Reset with random inputs
    drive($urandom % 2 == 1, rnd_pl(), AW'($urandom), $urandom % 2 == 1, $urandom % 2 == 1, 1'b0);
    #12;
    check_all("reset");
    chk("reset.out_valid", 128'(out_valid), 128'(0));
    chk("reset.in_ready", 128'(in_ready), 128'(1));
    @(negedge clk) rst = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    step("idle");

    // 2 Single op
    drive(1, 72'h1234, 5'd3, 1, 0, 0);
    step("single");
    chk("single.out_wd", 128'(out_wd), 128'(3));
    chk("single.out_wreg", 128'(out_wreg), 128'(1));
    chk("single.occ", 128'(occupancy), 128'(1));
    drive(0, '0, '0, 0, 1, 0);
    step("single_drain");

    // 3 Fill and backpressure
    A = 72'hA0A; B = 72'hB0B; C = 72'hC0C;
    drive(1, A, 5'd1, 1, 0, 0); step("fill_a");
    drive(1, B, 5'd2, 0, 0, 0); step("fill_b");
    drive(1, C, 5'd4, 1, 0, 0); step("fill_hold");
    chk("fill.in_ready", 128'(in_ready), 128'(0));
    chk("fill.head", 128'(out_payload), 128'(A));
    out_ready = 1'b1;
    step("drain1");
    chk("drain1.head", 128'(out_payload), 128'(B));
    step("drain2");
    chk("drain2.head", 128'(out_payload), 128'(C));
    in_valid = 1'b0;
    step("drain3");
    step("drain4");
    chk("drain.empty", 128'(out_valid), 128'(0));

    // 4 Streaming
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      drive(1, PW'(i + 100), AW'(i), 1, 1, 0);
      step("stream");
      chk("stream.occ", 128'(occupancy), 128'(1));
      chk("stream.head", 128'(out_payload), 128'(i + 100));
    end
    drive(0, '0, '0, 0, 1, 0);
    step("stream_drain");

    // 5 Flush while full, with enq and deq also requested
    drive(1, 72'h55, 5'd7, 1, 0, 0); step("pre_flush1");
    drive(1, 72'h66, 5'd8, 1, 0, 0); step("pre_flush2");
    chk("pre_flush.occ", 128'(occupancy), 128'(2));
    drive(1, 72'h77, 5'd9, 1, 1, 1); step("flush");
    chk("flush.occ", 128'(occupancy), 128'(0));
    chk("flush.out_wreg", 128'(out_wreg), 128'(0));
    drive(0, '0, '0, 0, 0, 0); step("post_flush");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 3 != 0, rnd_pl(), AW'($urandom), $urandom % 2 == 1,
            $urandom % 3 != 0, $urandom % 20 == 0);
      step("random");
    end

    // Asynchronous reset in the middle of traffic
    drive(1, 72'h99, 5'd5, 1, 0, 0); step("pre_rst");
    #2 rst = 1'b0;
    #1;
    q.delete(); m_bubble = 0; m_stall = 0;
    check_all("async_rst");
    @(negedge clk) rst = 1'b1;
    drive(0, '0, '0, 0, 0, 0);

`ifdef ID_EX_PERF_EN
    // 6 Perf counters
    drive(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("perf_empty");
    drive(1, 72'h1, 5'd1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step("perf_fill");
    for (int i = 0; i < 3; i++) step("perf_full");
    chk("perf.bubble", 128'(perf_bubble), 128'(4));
    chk("perf.stall", 128'(perf_stall), 128'(3));
    drive(0, '0, '0, 0, 0, 1); step("perf_flush");
    chk("perf.bubble_flush", 128'(perf_bubble), 128'(4));
    chk("perf.stall_flush", 128'(perf_stall), 128'(3));
    drive(0, '0, '0, 0, 0, 0);
`endif
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
